mdl_phase_acc: RTL

MDL_PHASE_ACC -- requirements
Module: mdl_phase_acc

---
 rtl/mdl_phase_acc.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mdl_phase_acc.sv
// mdl_phase_acc -- per-slot phase accumulator ring for an FM operator pipeline.
// Four-stage pipeline (frequency lookup, octave/detune, multiplier, accumulate)
// feeding a SLOTS-deep circular shift register of 20-bit phase accumulators.
// Optional feature macro: IKA2151_PG_DT1_EN enables the DT1 detune offset;
// without it i_DT1 is ignored and no detune logic is built.
module mdl_phase_acc #(
    parameter int SLOTS = 32
) (
    input  logic        i_EMUCLK,
    input  logic        i_MRST_n,
    input  logic        i_phi1_PCEN_n,
    input  logic        i_phi1_NCEN_n,
    input  logic        i_CYCLE_0,
    input  logic [12:0] i_PITCHVAL,
    input  logic [2:0]  i_DT1,
    input  logic [3:0]  i_MUL,
    input  logic        i_PHASE_RST,
    output logic [9:0]  o_PHASE,
    output logic [4:0]  o_SLOT
);

    // Pipeline registers; stage N holds the slot presented N enables ago.
    logic [11:0] s1_f;
    logic [2:0]  s1_oct;
    logic [3:0]  s1_mul;
    logic        s1_rst;
    logic [4:0]  s1_slot;
    logic [16:0] s2_inc;
    logic [3:0]  s2_mul;
    logic        s2_rst;
    logic [4:0]  s2_slot;
    logic [19:0] s3_step;
    logic        s3_rst;
    logic [4:0]  s3_slot;
    logic [19:0] ring [SLOTS];

    logic        en;
    logic [2:0]  oct;
    logic [3:0]  note;
    logic [3:0]  note_adj;
    logic [3:0]  idx;
    logic [5:0]  frac;
    logic [11:0] base;
    logic [7:0]  delta;
    logic [11:0] f_next;
    logic [4:0]  slot_next;
    logic [16:0] inc_base;
    logic [16:0] inc_next;
    logic [19:0] step_next;
    logic [19:0] acc_old;
    logic [19:0] acc_new;
    logic        unused_ok;

    assign en   = ~i_phi1_NCEN_n;
    assign oct  = i_PITCHVAL[12:10];
    assign note = i_PITCHVAL[9:6];
    assign frac = i_PITCHVAL[5:0];

    // Notes come in groups of four with only three valid; code 3 aliases code 2.
    assign note_adj = (note[1:0] == 2'b11) ? {note[3:2], 2'b10} : note;
    assign idx      = note_adj - {2'b00, note_adj[3:2]};

    // Base frequency and per-note interpolation slope for one octave.
    always_comb begin
        base  = 12'd0;
        delta = 8'd0;
        case (idx)
            4'd0:  begin base = 12'd1299; delta = 8'd77;  end
            4'd1:  begin base = 12'd1376; delta = 8'd82;  end
            4'd2:  begin base = 12'd1458; delta = 8'd87;  end
            4'd3:  begin base = 12'd1545; delta = 8'd92;  end
            4'd4:  begin base = 12'd1637; delta = 8'd97;  end
            4'd5:  begin base = 12'd1734; delta = 8'd103; end
            4'd6:  begin base = 12'd1837; delta = 8'd109; end
            4'd7:  begin base = 12'd1946; delta = 8'd116; end
            4'd8:  begin base = 12'd2062; delta = 8'd123; end
            4'd9:  begin base = 12'd2185; delta = 8'd130; end
            4'd10: begin base = 12'd2315; delta = 8'd137; end
            4'd11: begin base = 12'd2452; delta = 8'd146; end
            default: begin base = 12'd0; delta = 8'd0; end
        endcase
    end

    assign f_next = base + 12'(({6'd0, delta} * {8'd0, frac}) >> 6);

    // A cycle-0 marker always wins so a drifted counter realigns by itself.
    assign slot_next = i_CYCLE_0                   ? 5'd0 :
                       (s1_slot == 5'(SLOTS - 1))  ? 5'd0 :
                                                     s1_slot + 5'd1;

    // Octave scaling; the two dropped LSBs are the fixed-point alignment.
    assign inc_base = 17'(({7'd0, s1_f} << s1_oct) >> 2);

`ifdef IKA2151_PG_DT1_EN
    logic [2:0]  s1_dt1;
    logic [16:0] dt1_ofs;

    assign dt1_ofs  = 17'(s1_dt1[1:0]) * (17'(s1_oct) + 17'd1);
    // Detune wraps modulo 2^17 rather than clamping.
    assign inc_next = s1_dt1[2] ? (inc_base - dt1_ofs) : (inc_base + dt1_ofs);

    // Detune control delayed to line up with the octave stage.
    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n)  s1_dt1 <= 3'd0;
        else if (en)    s1_dt1 <= i_DT1;
    end

    assign unused_ok = &{1'b0, i_phi1_PCEN_n};
`else
    assign inc_next  = inc_base;
    assign unused_ok = &{1'b0, i_phi1_PCEN_n, i_DT1};
`endif

    // MUL=0 means one half; otherwise an integer multiple truncated to 20 bits.
    assign step_next = (s2_mul == 4'd0) ? {4'd0, s2_inc[16:1]}
                                        : 20'({3'd0, s2_inc} * {16'd0, s2_mul});

    // Key-on forces the accumulator to exactly zero, not zero plus step.
    assign acc_old = ring[SLOTS-1];
    assign acc_new = s3_rst ? 20'd0 : (acc_old + s3_step);

    // Pipeline, accumulator ring and outputs advance once per enable.
    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            s1_f    <= 12'd0;
            s1_oct  <= 3'd0;
            s1_mul  <= 4'd0;
            s1_rst  <= 1'b0;
            s1_slot <= 5'd0;
            s2_inc  <= 17'd0;
            s2_mul  <= 4'd0;
            s2_rst  <= 1'b0;
            s2_slot <= 5'd0;
            s3_step <= 20'd0;
            s3_rst  <= 1'b0;
            s3_slot <= 5'd0;
            for (int i = 0; i < SLOTS; i++) ring[i] <= 20'd0;
            o_PHASE <= 10'd0;
            o_SLOT  <= 5'd0;
        end else if (en) begin
            s1_f    <= f_next;
            s1_oct  <= oct;
            s1_mul  <= i_MUL;
            s1_rst  <= i_PHASE_RST;
            s1_slot <= slot_next;
            s2_inc  <= inc_next;
            s2_mul  <= s1_mul;
            s2_rst  <= s1_rst;
            s2_slot <= s1_slot;
            s3_step <= step_next;
            s3_rst  <= s2_rst;
            s3_slot <= s2_slot;
            for (int i = SLOTS - 1; i > 0; i--) ring[i] <= ring[i-1];
            ring[0] <= acc_new;
            o_PHASE <= acc_new[19:10];
            o_SLOT  <= s3_slot;
        end
    end

endmodule
